// File: rtl/bist_fail_log.sv
// Memory BIST fail logger: records failing compare cycles (address + error mask) in a small FIFO
// and keeps per-run statistics (saturating fail count, first failing address, overflow).
module bist_fail_log #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_active,
  input  logic              cmp_valid,
  input  logic [ADDR_W-1:0] cmp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] act_data,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_mask,
  output logic [CNT_W-1:0]  fail_count,
  output logic [ADDR_W-1:0] first_addr,
  output logic              any_fail,
  output logic              overflow,
  output logic              done
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = PW + 1;
  localparam int EW = ADDR_W + DATA_W;

  typedef enum logic [1:0] {IDLE, LOG, DONE} state_t;
  state_t state, state_nx;

  logic          ta_q;
  logic          start, log_en, mis, pop, push;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_n, rd_n, waddr;
  logic [OW-1:0] occ, occ_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [ADDR_W-1:0] first_n;
  logic              any_n, ovf_n;

  // A run starts only on a fresh 0->1 of test_active; the edge cycle already counts as logging.
  assign start  = test_active & ~ta_q & (state != LOG);
  assign log_en = (state == LOG) | start;
  assign mis    = log_en & cmp_valid & (exp_data != act_data);
  assign pop    = log_valid & log_ready & ~start;

  assign log_valid = (occ != '0);
  assign log_addr  = log_valid ? mem[rd_ptr][EW-1:DATA_W] : '0;
  assign log_mask  = log_valid ? mem[rd_ptr][DATA_W-1:0]  : '0;
  assign done      = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOG;
      LOG:     if (!test_active) state_nx = DONE;
      DONE:    if (start) state_nx = LOG;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wr_n    = wr_ptr;
    rd_n    = rd_ptr;
    occ_n   = occ;
    cnt_n   = fail_count;
    first_n = first_addr;
    any_n   = any_fail;
    ovf_n   = overflow;
    push    = 1'b0;
    if (start) begin
      wr_n    = '0;
      rd_n    = '0;
      occ_n   = '0;
      cnt_n   = '0;
      first_n = '0;
      any_n   = 1'b0;
      ovf_n   = 1'b0;
    end else if (pop) begin
      rd_n  = rd_ptr + 1'b1;
      occ_n = occ - 1'b1;
    end
    waddr = wr_n;
    // Fullness is judged after this cycle's pop, so full + push + pop never overflows.
    if (mis) begin
      if (cnt_n != '1) cnt_n = cnt_n + 1'b1;
      if (!any_n) first_n = cmp_addr;
      any_n = 1'b1;
      if (occ_n != OW'(DEPTH)) begin
        push  = 1'b1;
        wr_n  = wr_n + 1'b1;
        occ_n = occ_n + 1'b1;
      end else begin
        ovf_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      // Held high so a test_active asserted through reset must drop before a run can start.
      ta_q       <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      fail_count <= '0;
      first_addr <= '0;
      any_fail   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      ta_q       <= test_active;
      wr_ptr     <= wr_n;
      rd_ptr     <= rd_n;
      occ        <= occ_n;
      fail_count <= cnt_n;
      first_addr <= first_n;
      any_fail   <= any_n;
      overflow   <= ovf_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[waddr] <= {cmp_addr, exp_data ^ act_data};
  end
endmodule

// File: tb/tb_bist_fail_log.sv
// Directed bench for bist_fail_log: default instance plus a CNT_W=3 instance for saturation.
module tb_bist_fail_log;
  logic       clk = 0, rst = 1, test_active = 0, cmp_valid = 0, log_ready = 0;
  logic [5:0] cmp_addr = 0;
  logic [7:0] exp_data = 0, act_data = 0;

  logic       lv, any, ovf, dn;
  logic [5:0] la, fa;
  logic [7:0] lm;
  logic [9:0] fc;
  logic       lv3, any3, ovf3, dn3;
  logic [5:0] la3, fa3;
  logic [7:0] lm3;
  logic [2:0] fc3;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  bist_fail_log dut (
    .clk(clk), .rst(rst), .test_active(test_active), .cmp_valid(cmp_valid),
    .cmp_addr(cmp_addr), .exp_data(exp_data), .act_data(act_data),
    .log_valid(lv), .log_ready(log_ready), .log_addr(la), .log_mask(lm),
    .fail_count(fc), .first_addr(fa), .any_fail(any), .overflow(ovf), .done(dn));

  bist_fail_log #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .test_active(test_active), .cmp_valid(cmp_valid),
    .cmp_addr(cmp_addr), .exp_data(exp_data), .act_data(act_data),
    .log_valid(lv3), .log_ready(log_ready), .log_addr(la3), .log_mask(lm3),
    .fail_count(fc3), .first_addr(fa3), .any_fail(any3), .overflow(ovf3), .done(dn3));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cmp(input logic [5:0] a, input logic [7:0] e, input logic [7:0] x);
    cmp_valid = 1; cmp_addr = a; exp_data = e; act_data = x;
    step();
    cmp_valid = 0; exp_data = 0; act_data = 0;
  endtask

  task automatic pop();
    log_ready = 1; step(); log_ready = 0;
  endtask

  task automatic start_run();
    test_active = 0; step();
    test_active = 1; step();
  endtask

  task automatic end_run();
    test_active = 0; step();
  endtask

  task automatic test_reset();
    rst = 1; test_active = 1;
    repeat (3) step();
    rst = 0;
    cmp(6'd3, 8'hAA, 8'h55);
    step();
    n_chk++; if ({lv, la, lm} !== 15'd0) begin n_fail++; $display("FAIL reset_fifo got lv=%0b a=%0h m=%0h exp 0", lv, la, lm); end
    n_chk++; if (fc !== 10'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fc); end
    n_chk++; if ({fa, any, ovf, dn} !== 9'd0) begin n_fail++; $display("FAIL reset_flags got fa=%0h any=%0b ovf=%0b done=%0b exp 0", fa, any, ovf, dn); end
    end_run();
  endtask

  task automatic test_basic();
    start_run();
    cmp(6'd5, 8'h0F, 8'h0B);
    n_chk++; if (fc !== 10'd1 || lv !== 1'b1) begin n_fail++; $display("FAIL basic_latency got fc=%0d lv=%0b exp 1 1", fc, lv); end
    cmp(6'd9, 8'h33, 8'h31);
    cmp(6'd7, 8'h5A, 8'h5A);
    step();
    n_chk++; if (la !== 6'd5 || lm !== 8'h04) begin n_fail++; $display("FAIL basic_head0 got %0d/%0h exp 5/04", la, lm); end
    n_chk++; if (fc !== 10'd2 || fa !== 6'd5 || any !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL basic_stats got fc=%0d fa=%0d any=%0b ovf=%0b exp 2 5 1 0", fc, fa, any, ovf); end
    step();
    n_chk++; if (la !== 6'd5 || lm !== 8'h04) begin n_fail++; $display("FAIL basic_hold got %0d/%0h exp 5/04", la, lm); end
    pop();
    n_chk++; if (lv !== 1'b1 || la !== 6'd9 || lm !== 8'h02) begin n_fail++; $display("FAIL basic_head1 got %0b %0d/%0h exp 1 9/02", lv, la, lm); end
    pop();
    n_chk++; if (lv !== 1'b0) begin n_fail++; $display("FAIL basic_empty got lv=%0b exp 0", lv); end
    pop();
    n_chk++; if (lv !== 1'b0) begin n_fail++; $display("FAIL basic_empty_pop got lv=%0b exp 0", lv); end
    end_run();
  endtask

  task automatic test_overflow();
    start_run();
    for (int i = 0; i < 6; i++) cmp(6'(10 + i), 8'hFF, 8'hFF ^ 8'(1 << i));
    n_chk++; if (fc !== 10'd6 || ovf !== 1'b1 || fa !== 6'd10) begin n_fail++; $display("FAIL ovf_stats got fc=%0d ovf=%0b fa=%0d exp 6 1 10", fc, ovf, fa); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (lv !== 1'b1 || la !== 6'(10 + i) || lm !== 8'(1 << i)) begin n_fail++; $display("FAIL ovf_entry%0d got %0b %0d/%0h exp 1 %0d/%0h", i, lv, la, lm, 10 + i, 1 << i); end
      pop();
    end
    n_chk++; if (lv !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got lv=%0b exp 0", lv); end
    end_run();
  endtask

  task automatic test_full_push_pop();
    start_run();
    for (int i = 0; i < 4; i++) cmp(6'(20 + i), 8'h00, 8'h01);
    log_ready = 1;
    cmp(6'd24, 8'h00, 8'h80);
    log_ready = 0;
    n_chk++; if (ovf !== 1'b0 || fc !== 10'd5) begin n_fail++; $display("FAIL fpp_stats got ovf=%0b fc=%0d exp 0 5", ovf, fc); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (lv !== 1'b1 || la !== 6'(21 + i) || lm !== ((i == 3) ? 8'h80 : 8'h01)) begin n_fail++; $display("FAIL fpp_entry%0d got %0b %0d/%0h exp 1 %0d", i, lv, la, lm, 21 + i); end
      pop();
    end
    n_chk++; if (lv !== 1'b0) begin n_fail++; $display("FAIL fpp_drained got lv=%0b exp 0", lv); end
    end_run();
  endtask

  task automatic test_saturate();
    start_run();
    for (int i = 0; i < 9; i++) cmp(6'(30 + i), 8'h00, 8'h01);
    n_chk++; if (fc3 !== 3'd7) begin n_fail++; $display("FAIL sat_count3 got %0d exp 7", fc3); end
    n_chk++; if (fc !== 10'd9) begin n_fail++; $display("FAIL sat_count10 got %0d exp 9", fc); end
    n_chk++; if (ovf3 !== 1'b1 || fa3 !== 6'd30) begin n_fail++; $display("FAIL sat_flags got ovf=%0b fa=%0d exp 1 30", ovf3, fa3); end
    end_run();
    test_active = 1; step();
    n_chk++; if ({fc3, fa3, any3, ovf3, lv3, dn3} !== 13'd0) begin n_fail++; $display("FAIL sat_clear got fc=%0d fa=%0d any=%0b ovf=%0b lv=%0b dn=%0b exp 0", fc3, fa3, any3, ovf3, lv3, dn3); end
    n_chk++; if (fc !== 10'd0 || lv !== 1'b0) begin n_fail++; $display("FAIL sat_clear10 got fc=%0d lv=%0b exp 0 0", fc, lv); end
    end_run();
  endtask

  task automatic test_done_drain();
    start_run();
    cmp(6'd40, 8'hF0, 8'hE0);
    cmp(6'd41, 8'hF0, 8'hD0);
    n_chk++; if (dn !== 1'b0) begin n_fail++; $display("FAIL done_in_log got %0b exp 0", dn); end
    end_run();
    n_chk++; if (dn !== 1'b1 || lv !== 1'b1) begin n_fail++; $display("FAIL done_state got dn=%0b lv=%0b exp 1 1", dn, lv); end
    cmp(6'd42, 8'h00, 8'hFF);
    n_chk++; if (fc !== 10'd2) begin n_fail++; $display("FAIL done_ignore got fc=%0d exp 2", fc); end
    n_chk++; if (la !== 6'd40 || lm !== 8'h10) begin n_fail++; $display("FAIL done_e0 got %0d/%0h exp 40/10", la, lm); end
    pop();
    n_chk++; if (la !== 6'd41 || lm !== 8'h20) begin n_fail++; $display("FAIL done_e1 got %0d/%0h exp 41/20", la, lm); end
    pop();
    n_chk++; if (lv !== 1'b0 || fc !== 10'd2 || fa !== 6'd40 || any !== 1'b1 || dn !== 1'b1) begin n_fail++; $display("FAIL done_final got lv=%0b fc=%0d fa=%0d any=%0b dn=%0b exp 0 2 40 1 1", lv, fc, fa, any, dn); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_saturate();
    test_done_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
